// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the ping-pong pulse capture buffer: default sizing,
// FSM state encoding and a helper that packs per-channel samples into a word.
package pulse_capture_pkg;

  localparam int DEF_NCH   = 2;
  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 512;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_e;

  typedef logic [DEF_DW-1:0]         chan_t;
  typedef logic [DEF_NCH*DEF_DW-1:0] word_t;

  // Channel k lands in bits [k*DW +: DW] of the packed word.
  function automatic word_t pack_word(input chan_t ch [DEF_NCH]);
    word_t w;
    w = '0;
    for (int k = 0; k < DEF_NCH; k++) begin
      w[k*DEF_DW +: DEF_DW] = ch[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_capture_buf_if.sv
// Bundle of the ADC-side capture controls and the host-side readout signals.
// The master modport is the front-end/host driving the buffer; the slave
// modport is the buffer itself.
interface pulse_capture_buf_if
  import pulse_capture_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic              GEN;
  logic [AW:0]       PULSE_NUM;
  logic              VALID;
  logic [NCH*DW-1:0] DATA_IN;
  logic              BUSY;
  logic              DONE;
  logic              RESTART_ERR;
  logic              WR_BANK;
  logic [AW-1:0]     ADDR;
  logic [NCH*DW-1:0] RD_DATA;

  modport master (
    output GEN, PULSE_NUM, VALID, DATA_IN, ADDR,
    input  BUSY, DONE, RESTART_ERR, WR_BANK, RD_DATA
  );

  modport slave (
    input  GEN, PULSE_NUM, VALID, DATA_IN, ADDR,
    output BUSY, DONE, RESTART_ERR, WR_BANK, RD_DATA
  );

endinterface

// File: rtl/pulse_capture_dpram.sv
// Simple dual-port RAM holding both capture banks: one synchronous write
// port and one registered read port. Kept separate so block-RAM inference
// is not disturbed by the control logic around it. Only the read register
// is reset; the array contents are left untouched by reset.
module pulse_capture_dpram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  // Write port: one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read address decode ahead of the output register.
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Registered read data, cleared by reset so the host sees zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pulse_capture_buf.sv
// Ping-pong capture buffer for multi-channel ADC pulse samples. A GEN rising
// edge arms a capture of PULSE_NUM words into the write bank, one word per
// VALID falling edge, while the host reads the other (completed) bank.
module pulse_capture_buf
  import pulse_capture_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                CLOCK_10M,
  input logic                RESET_N,
  pulse_capture_buf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = NCH * DW;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE    = S_IDLE;
  localparam logic [0:0] ST_CAPTURE = S_CAPTURE;

  // Requests larger than one bank are clipped to the bank size.
  function automatic logic [AW:0] sat_target(input logic [AW:0] n);
    return (n > DEPTH_W) ? DEPTH_W : n;
  endfunction

  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] index_q,   index_d;
  logic [AW:0]   target_q,  target_d;
  logic          wr_bank_q, wr_bank_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;
  logic          gen_q,     gen_d;
  logic          valid_q,   valid_d;
  logic [W-1:0]  samp_q,    samp_d;

  logic          gen_rise;
  logic          valid_fall;
  logic [AW:0]   idx_next;
  logic [AW:0]   gen_target;
  logic          ram_we;
  logic [AW:0]   ram_waddr;
  logic [AW:0]   ram_raddr;

  assign gen_rise   = bus.GEN & ~gen_q;
  assign valid_fall = ~bus.VALID & valid_q;
  assign idx_next   = {1'b0, index_q} + (AW+1)'(1);
  assign gen_target = sat_target(bus.PULSE_NUM);

  // Edge-detect history and the sample latch that tracks DATA_IN while VALID
  // is high, so the word written on the falling edge is the last one seen.
  always_comb begin
    gen_d   = bus.GEN;
    valid_d = bus.VALID;
    samp_d  = bus.VALID ? bus.DATA_IN : samp_q;
  end

  // Capture FSM: arm on GEN, write on each VALID fall, abort on re-trigger.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    target_d  = target_q;
    wr_bank_d = wr_bank_q;
    done_d    = 1'b0;
    err_d     = err_q;
    ram_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gen_rise) begin
          wr_bank_d = ~wr_bank_q;
          target_d  = gen_target;
          index_d   = '0;
          if (gen_target == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (valid_fall) begin
          ram_we  = 1'b1;
          index_d = idx_next[AW-1:0];
          if (idx_next == target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        // A re-trigger wins over completion; the write above still lands.
        if (gen_rise) begin
          err_d    = 1'b1;
          index_d  = '0;
          target_d = gen_target;
          state_d  = ST_CAPTURE;
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      target_q  <= '0;
      wr_bank_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      gen_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      target_q  <= target_d;
      wr_bank_q <= wr_bank_d;
      done_q    <= done_d;
      err_q     <= err_d;
      gen_q     <= gen_d;
      valid_q   <= valid_d;
    end
  end

  // Sample data register; pure datapath, no reset needed.
  always_ff @(posedge CLOCK_10M) begin
    samp_q <= samp_d;
  end

  // The bank bit is the RAM MSB; reads always target the bank not being written.
  assign ram_waddr = {wr_bank_q, index_q};
  assign ram_raddr = {~wr_bank_q, bus.ADDR};

  pulse_capture_dpram #(
    .W  (W),
    .AW (AW + 1)
  ) u_ram (
    .clk   (CLOCK_10M),
    .rst_n (RESET_N),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (samp_q),
    .raddr (ram_raddr),
    .rdata (bus.RD_DATA)
  );

  assign bus.BUSY        = (state_q == ST_CAPTURE);
  assign bus.DONE        = done_q;
  assign bus.RESTART_ERR = err_q;
  assign bus.WR_BANK     = wr_bank_q;

endmodule

// File: tb/tb_pulse_capture_buf.sv
// Bench for pulse_capture_buf: directed table vectors, hand sequences for
// abort/reset corners, and a randomized phase against a transaction-level
// model of the two banks.
module tb_pulse_capture_buf;
  import pulse_capture_pkg::*;

  localparam int NCH   = DEF_NCH;
  localparam int DW    = DEF_DW;
  localparam int DEPTH = DEF_DEPTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = NCH * DW;

  logic clk;
  logic rst_n;

  pulse_capture_buf_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

  pulse_capture_buf #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLOCK_10M (clk),
    .RESET_N   (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: contents of both banks plus capture bookkeeping.
  logic [W-1:0] m_mem [2][DEPTH];
  bit           m_vld [2][DEPTH];
  bit           m_bank;
  bit           m_busy;
  bit           m_err;
  int           m_target;
  int           m_count;

  typedef struct {
    logic [W-1:0] data;
    logic         exp_done;
    logic         exp_busy;
  } vec_t;

  vec_t tv [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_bank   = 1'b0;
    m_busy   = 1'b0;
    m_err    = 1'b0;
    m_target = 0;
    m_count  = 0;
  endfunction

  // Returns whether DONE is expected after this strobe.
  function automatic logic m_strobe(input logic [W-1:0] w);
    logic d;
    d = 1'b0;
    if (m_busy) begin
      m_mem[m_bank][m_count] = w;
      m_vld[m_bank][m_count] = 1'b1;
      m_count++;
      if (m_count == m_target) begin
        m_busy = 1'b0;
        d      = 1'b1;
      end
    end
    return d;
  endfunction

  task automatic do_gen(input int n);
    int   t;
    logic exp_done;
    t        = (n > DEPTH) ? DEPTH : n;
    exp_done = 1'b0;
    if (m_busy) begin
      m_err    = 1'b1;
      m_count  = 0;
      m_target = t;
    end else begin
      m_bank   = ~m_bank;
      m_count  = 0;
      m_target = t;
      if (t == 0) exp_done = 1'b1;
      else        m_busy   = 1'b1;
    end
    @(negedge clk);
    bus.GEN       = 1'b1;
    bus.PULSE_NUM = n[AW:0];
    @(negedge clk);
    check("gen_busy",    bus.BUSY,        m_busy);
    check("gen_done",    bus.DONE,        exp_done);
    check("gen_wr_bank", bus.WR_BANK,     m_bank);
    check("gen_err",     bus.RESTART_ERR, m_err);
    bus.GEN = 1'b0;
  endtask

  // One VALID pulse; DATA_IN is scrambled after VALID drops so only the word
  // seen while VALID was high may be stored.
  task automatic strobe(input logic [W-1:0] w, output logic d, output logic b);
    @(negedge clk);
    bus.VALID   = 1'b1;
    bus.DATA_IN = w;
    @(negedge clk);
    bus.VALID   = 1'b0;
    bus.DATA_IN = $urandom;
    check("strobe_early_done", bus.DONE, 1'b0);
    @(negedge clk);
    d = bus.DONE;
    b = bus.BUSY;
  endtask

  task automatic strobe_chk(input logic [W-1:0] w);
    logic exp_d, d, b;
    exp_d = m_strobe(w);
    strobe(w, d, b);
    check("strobe_done", d, exp_d);
    check("strobe_busy", b, m_busy);
  endtask

  task automatic read_chk(input int a);
    int rb;
    rb = m_bank ? 0 : 1;
    @(negedge clk);
    bus.ADDR = a[AW-1:0];
    @(negedge clk);
    if (m_vld[rb][a]) check("read_data", bus.RD_DATA, m_mem[rb][a]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bus.GEN   = 1'b0;
    bus.VALID = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    chan_t        c [NCH];
    logic         d, b;
    logic [W-1:0] w;
    int           r;

    for (int i = 0; i < 4; i++) begin
      c[0] = chan_t'(i);
      c[1] = chan_t'(i + 1);
      tv[i].data     = pack_word(c);
      tv[i].exp_done = (i == 3);
      tv[i].exp_busy = (i != 3);
    end

    rst_n         = 1'b0;
    bus.GEN       = 1'b0;
    bus.PULSE_NUM = '0;
    bus.VALID     = 1'b0;
    bus.DATA_IN   = '0;
    bus.ADDR      = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_busy",    bus.BUSY,        1'b0);
    check("rst_done",    bus.DONE,        1'b0);
    check("rst_err",     bus.RESTART_ERR, 1'b0);
    check("rst_wr_bank", bus.WR_BANK,     1'b0);
    check("rst_rd_data", bus.RD_DATA,     '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four-word capture into bank 1, driven from the vector table.
    do_gen(4);
    for (int i = 0; i < 4; i++) begin
      void'(m_strobe(tv[i].data));
      strobe(tv[i].data, d, b);
      check("tv_done", d, tv[i].exp_done);
      check("tv_busy", b, tv[i].exp_busy);
    end
    check("tv_wr_bank", bus.WR_BANK, 1'b1);

    // Oversized request: clipped to DEPTH words in bank 0; bank 1 stays readable.
    do_gen(DEPTH + 100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ADDR = AW'(i);
      @(negedge clk);
      check("tv_read", bus.RD_DATA, tv[i].data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      strobe_chk($urandom);
      if (i % 64 == 0) read_chk(i % 4);
    end
    check("full_busy_end", bus.BUSY, 1'b0);

    // Zero-length request: DONE straight away, never BUSY, no writes.
    do_gen(0);
    repeat (2) begin
      @(negedge clk);
      check("zero_busy", bus.BUSY, 1'b0);
      check("zero_done", bus.DONE, 1'b0);
    end
    read_chk(0);
    read_chk(DEPTH - 1);
    read_chk(137);

    // VALID activity while idle must not write anything.
    for (int i = 0; i < 3; i++) strobe_chk(32'hDEAD_BEEF);
    read_chk(0);
    read_chk(DEPTH - 1);
    do_gen(0);
    for (int i = 0; i < 4; i++) read_chk(i);

    // Re-trigger after two of eight strobes: abort, index restarts, bank kept.
    do_gen(8);
    strobe_chk(32'h1111_0001);
    strobe_chk(32'h1111_0002);
    do_gen(8);
    check("abort_err", bus.RESTART_ERR, 1'b1);
    for (int i = 0; i < 8; i++) strobe_chk(32'h2222_0000 + i);
    check("abort_err_sticky", bus.RESTART_ERR, 1'b1);
    do_gen(0);
    for (int i = 0; i < 8; i++) read_chk(i);

    // Randomized mix of triggers, strobes and reads.
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        if (m_busy) do_gen($urandom_range(1, 12));
        else        do_gen($urandom_range(0, 12));
      end else if (r < 8) begin
        repeat ($urandom_range(1, 6)) strobe_chk($urandom);
      end else begin
        repeat (3) read_chk($urandom_range(0, 15));
      end
    end

    // Asynchronous reset in the middle of a capture.
    do_reset();
    do_gen(6);
    for (int i = 0; i < 3; i++) strobe_chk(32'h3333_0000 + i);
    @(negedge clk);
    #10 rst_n = 1'b0;
    #1;
    check("arst_busy",    bus.BUSY,        1'b0);
    check("arst_done",    bus.DONE,        1'b0);
    check("arst_err",     bus.RESTART_ERR, 1'b0);
    check("arst_wr_bank", bus.WR_BANK,     1'b0);
    check("arst_rd_data", bus.RD_DATA,     '0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_gen(4);
    check("post_rst_bank", bus.WR_BANK, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w = 32'h4444_0000 + i;
      strobe_chk(w);
    end
    do_gen(0);
    for (int i = 0; i < 4; i++) read_chk(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_capture_buf.md
Name: pulse_capture_buf

Overview:
- Parametrised, double-buffered (ping-pong) capture buffer for multi-channel ADC pulse samples.
- Sits between the ADC front-end (sample word + VALID strobe) and the readout/host side (ADDR -> RD_DATA).
- GEN arms a capture of PULSE_NUM samples into the write bank. The host reads the previously completed bank concurrently.
- Sample strobing is fully synchronous to CLOCK_10M; VALID is never used as a clock.

Parameters:
- NCH, 2, number of ADC channels packed per word.
- DW, 16, bits per channel sample.
- DEPTH, 512, words per bank; must be a power of two, >= 2.
- AW, $clog2(DEPTH), address width per bank (derived, not overridden).

Ports:
- CLOCK_10M  in  1  sole clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- GEN  in  1  capture trigger; level input, rising edge detected internally.
- PULSE_NUM  in  AW+1  samples to capture per GEN; sampled on the GEN edge.
- VALID  in  1  ADC sample strobe; a word is written on each detected falling edge.
- DATA_IN  in  NCH*DW  channel samples; channel k occupies bits [k*DW +: DW].
- BUSY  out  1  high while capturing.
- DONE  out  1  one-cycle pulse when a capture completes.
- RESTART_ERR  out  1  sticky; set when GEN arrives during a capture.
- WR_BANK  out  1  bank currently being written; the host reads bank ~WR_BANK.
- ADDR  in  AW  read address within the read bank.
- RD_DATA  out  NCH*DW  read data, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release) drives:
  - state = IDLE
  - BUSY = 0, DONE = 0, RESTART_ERR = 0, WR_BANK = 0, RD_DATA = 0
  - index = 0, VALID/GEN edge registers = 0
  - RAM contents are not reset.
- Edge detection:
  - gen_q and valid_q are one-cycle delayed copies of GEN and VALID.
  - gen_rise = GEN & ~gen_q.
  - valid_fall = ~VALID & valid_q.
  - The inputs are assumed synchronous to CLOCK_10M; no synchroniser is included.
- Sample latch: DATA_IN is registered into samp_q on every cycle VALID=1. On valid_fall, samp_q (the last word seen while VALID was high) is written.
- State machine:
  - IDLE: on gen_rise:
    - WR_BANK toggles.
    - target = min(PULSE_NUM, DEPTH); index = 0.
    - If target == 0: go to IDLE and pulse DONE next cycle, with no writes.
    - Otherwise go to CAPTURE.
  - CAPTURE: BUSY = 1. On valid_fall, write samp_q to RAM[{WR_BANK, index}] and increment index. When the write makes index+1 == target, go to IDLE, pulse DONE on the following cycle, and drop BUSY in that same cycle.
  - CAPTURE with gen_rise: abort. Set RESTART_ERR, do NOT toggle WR_BANK, reset index = 0, reload target, and remain in CAPTURE. A gen_rise that coincides with the final valid_fall is treated as an abort; the final write still occurs.
- RESTART_ERR is cleared only by reset.
- No writes are ever issued in IDLE; valid_fall in IDLE is ignored.
- Read port: RD_DATA <= RAM[{~WR_BANK, ADDR}]. Latency is 1 cycle. The bank select applies combinationally at the cycle the address is sampled, so a read in the same cycle as a WR_BANK toggle returns old-bank data.
- Read and write banks are always disjoint, so no read/write collision is possible.
- BUSY reflects the registered state, high from the cycle after gen_rise.

Decomposition:
- Package pulse_capture_pkg holds:
  - state enum (IDLE, CAPTURE)
  - default NCH/DW/DEPTH constants
  - a word-packing function
- Sub-module pulse_capture_dpram: simple dual-port RAM with 2*DEPTH words of NCH*DW bits, one synchronous write port and one registered read port. It keeps block-RAM inference isolated.

Test Plan:
- Reset release, then GEN rise with PULSE_NUM=4 and four VALID pulses carrying DATA_IN 0x0001_0000..0x0004_0003 -> BUSY high 4 strobes; DONE pulses once; WR_BANK=1; reading ADDR 0..3 returns those words 1 cycle later.
- Second GEN with PULSE_NUM=DEPTH+100 -> exactly DEPTH words written to bank 0; DONE after the DEPTH-th strobe; the previous bank remains readable throughout.
- PULSE_NUM=0 -> DONE one cycle after the GEN edge; BUSY never high; RAM unchanged.
- GEN re-asserted after 2 of 8 strobes -> RESTART_ERR=1; WR_BANK unchanged; index restarts; 8 more strobes needed for DONE; RESTART_ERR stays high.
- VALID toggling in IDLE with DATA_IN=0xDEAD_BEEF -> no RAM writes; readback unchanged.
- RESET_N asserted mid-capture (after 3 of 6 strobes) -> all outputs immediately at reset values; the next GEN starts cleanly at index 0 in bank 1.
